conv_1x1_accum: RTL and testbench

Consumer of the FP32 product stream emitted by the 1x1 convolution core. Products arrive channel-major: all IMAGE_SIZE pixel products for input channel 0, then channel 1, and so on. The block sums CHANNEL_NUM_IN products per pixel in an IMAGE_SIZE-entry partial-sum RAM. It emits one finished output-channel pixel stream per CHANNEL_NUM_IN input channels and then repeats for the next output channel.

---
 rtl/conv_1x1_accum.sv | 209 ++++++++++++++++++++
 tb/tb_conv_1x1_accum.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_1x1_accum.sv
// conv_1x1_accum: accumulates channel-major FP32 products of a 1x1 convolution
// into a per-pixel partial-sum RAM. One finished output-channel pixel stream
// is produced every CHANNEL_NUM_IN input channels.
module conv_1x1_accum #(
    parameter int DATA_WIDTH      = 32,
    parameter int IMAGE_WIDTH     = 16,
    parameter int IMAGE_HEIGHT    = 16,
    parameter int CHANNEL_NUM_IN  = 256,
    parameter int CHANNEL_NUM_OUT = 512,
    parameter int FP_ADD_LATENCY  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  frame_done,
    output logic                  layer_done
);

    localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int PIX_W = (IMAGE_SIZE > 1)      ? $clog2(IMAGE_SIZE)      : 1;
    localparam int CH_W  = (CHANNEL_NUM_IN > 1)  ? $clog2(CHANNEL_NUM_IN)  : 1;
    localparam int OCH_W = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(IMAGE_SIZE - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNEL_NUM_IN - 1);
    localparam logic [OCH_W-1:0] OCH_LAST = OCH_W'(CHANNEL_NUM_OUT - 1);
    localparam int L = FP_ADD_LATENCY;

    // A pixel's next product must not be read before its previous sum is written.
    if (IMAGE_SIZE < FP_ADD_LATENCY + 2) begin : g_bad_image_size
        $fatal(1, "conv_1x1_accum: IMAGE_SIZE must be >= FP_ADD_LATENCY+2");
    end
    if (FP_ADD_LATENCY < 1 || DATA_WIDTH != 32) begin : g_bad_adder_cfg
        $fatal(1, "conv_1x1_accum: needs DATA_WIDTH=32 and FP_ADD_LATENCY>=1");
    end

    typedef struct packed {
        logic [PIX_W-1:0] pix;
        logic             first;
        logic             last;
        logic             frame_end;
        logic             layer_end;
    } tag_t;

    // IEEE-754 single add, round to nearest even; subnormals handled, inf/NaN passed.
    function automatic logic [31:0] fp32_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y, res;
        logic [7:0]  ex, ey, d;
        logic [26:0] mx, my, my_sh, my_al;
        logic [27:0] sum;
        logic [24:0] mant;
        int          e;
        // Larger magnitude first so only the smaller operand is ever shifted.
        if (b[30:0] > a[30:0]) begin x = b; y = a; end
        else                   begin x = a; y = b; end
        ex    = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        ey    = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
        mx    = {x[30:23] != 8'd0, x[22:0], 3'b000};
        my    = {y[30:23] != 8'd0, y[22:0], 3'b000};
        d     = ex - ey;
        my_sh = my >> d;
        my_al = my_sh | {26'd0, (my_sh << d) != my};
        e     = {24'd0, ex};
        if (x[31] == y[31]) begin
            sum = {1'b0, mx} + {1'b0, my_al};
            if (sum[27]) begin
                sum = {1'b0, sum[27:2], sum[1] | sum[0]};
                e   = e + 1;
            end
        end else begin
            sum = {1'b0, mx - my_al};
            for (int i = 0; i < 26; i++) begin
                if (!sum[26] && e > 1) begin
                    sum = sum << 1;
                    e   = e - 1;
                end
            end
        end
        mant = {1'b0, sum[26:3]};
        if (sum[2] && (sum[1] || sum[0] || sum[3])) mant = mant + 25'd1;
        if (mant[24]) begin
            mant = mant >> 1;
            e    = e + 1;
        end
        if (x[30:23] == 8'hFF || y[30:23] == 8'hFF)
            res = (x[30:23] == 8'hFF && y[30:23] == 8'hFF && x[31] != y[31]) ? 32'h7FC0_0000 : x;
        else if (sum == '0)
            res = {x[31] & y[31], 31'd0};
        else if (e >= 255)
            res = {x[31], 8'hFF, 23'd0};
        else
            res = {x[31], mant[23] ? e[7:0] : 8'd0, mant[22:0]};
        return res;
    endfunction

    logic [PIX_W-1:0]      r_pix_cnt;
    logic [CH_W-1:0]       r_ch_cnt;
    logic [OCH_W-1:0]      r_och_cnt;
    tag_t                  w_tag;
    logic                  r_s1_valid;
    tag_t                  r_s1_tag;
    logic [31:0]           r_s1_prod;
    logic [31:0]           r_ram_rd;
    logic [31:0]           r_ram [IMAGE_SIZE];
    logic [31:0]           w_op_a;
    logic [31:0]           w_sum;
    logic [31:0]           r_sum_pipe [L];
    logic [L-1:0]          r_vld_pipe;
    tag_t                  r_tag_pipe [L];

    // Input position counters: pixel fastest, then input channel, then output channel.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pix_cnt <= '0;
            r_ch_cnt  <= '0;
            r_och_cnt <= '0;
        end else if (valid_in) begin
            if (r_pix_cnt == PIX_LAST) begin
                r_pix_cnt <= '0;
                if (r_ch_cnt == CH_LAST) begin
                    r_ch_cnt  <= '0;
                    r_och_cnt <= (r_och_cnt == OCH_LAST) ? '0 : r_och_cnt + 1'b1;
                end else begin
                    r_ch_cnt <= r_ch_cnt + 1'b1;
                end
            end else begin
                r_pix_cnt <= r_pix_cnt + 1'b1;
            end
        end
    end

    // Tag describing where the current product sits in the layer.
    // NOTE: every field is assigned on every pass, so no latch can be inferred.
    always_comb begin
        w_tag           = '0;
        w_tag.pix       = r_pix_cnt;
        w_tag.first     = (r_ch_cnt == '0);
        w_tag.last      = (r_ch_cnt == CH_LAST);
        w_tag.frame_end = w_tag.last && (r_pix_cnt == PIX_LAST);
        w_tag.layer_end = w_tag.frame_end && (r_och_cnt == OCH_LAST);
    end

    // Stage 1 control: product valid and tag registered alongside the RAM read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_tag   <= '0;
        end else begin
            r_s1_valid <= valid_in;
            if (valid_in) r_s1_tag <= w_tag;
        end
    end

    // Partial-sum RAM: synchronous read for stage 1, writeback of finished sums.
    // NOTE: RAM and datapath flops have no reset; valids gate them and channel 0 ignores stale data.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            r_s1_prod <= pxl_in;
            r_ram_rd  <= r_ram[r_pix_cnt];
        end
        if (r_vld_pipe[L-1]) r_ram[r_tag_pipe[L-1].pix] <= r_sum_pipe[L-1];
    end

    // Stage 2 operands: channel 0 starts from zero instead of the stored sum.
    always_comb begin
        w_op_a = r_s1_tag.first ? 32'h0 : r_ram_rd;
        w_sum  = fp32_add(w_op_a, r_s1_prod);
    end

    // Adder result pipeline, FP_ADD_LATENCY stages deep.
    always_ff @(posedge clk) begin
        r_sum_pipe[0] <= w_sum;
        for (int i = 1; i < L; i++) r_sum_pipe[i] <= r_sum_pipe[i-1];
    end

    // Valid/tag delay line matching the adder pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_pipe <= '0;
            for (int i = 0; i < L; i++) r_tag_pipe[i] <= '0;
        end else begin
            r_vld_pipe[0] <= r_s1_valid;
            r_tag_pipe[0] <= r_s1_tag;
            for (int i = 1; i < L; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_tag_pipe[i] <= r_tag_pipe[i-1];
            end
        end
    end

    // Output register: the last channel's sum is the finished pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pxl_out    <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            layer_done <= 1'b0;
        end else begin
            valid_out  <= r_vld_pipe[L-1] && r_tag_pipe[L-1].last;
            frame_done <= r_vld_pipe[L-1] && r_tag_pipe[L-1].frame_end;
            layer_done <= r_vld_pipe[L-1] && r_tag_pipe[L-1].layer_end;
            if (r_vld_pipe[L-1] && r_tag_pipe[L-1].last) pxl_out <= r_sum_pipe[L-1];
        end
    end

endmodule

// File: tb/tb_conv_1x1_accum.sv
// Testbench for conv_1x1_accum in the small 4x2 image, 3-in / 2-out channel config.
module tb_conv_1x1_accum;

    localparam int IW   = 4;
    localparam int IH   = 2;
    localparam int CIN  = 3;
    localparam int COUT = 2;
    localparam int LAT  = 4;
    localparam int NPIX = IW * IH;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [31:0] pxl_in;
    logic [31:0] pxl_out;
    logic        valid_out;
    logic        frame_done;
    logic        layer_done;

    conv_1x1_accum #(
        .DATA_WIDTH(32), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH),
        .CHANNEL_NUM_IN(CIN), .CHANNEL_NUM_OUT(COUT), .FP_ADD_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
        .pxl_out(pxl_out), .valid_out(valid_out),
        .frame_done(frame_done), .layer_done(layer_done)
    );

    always #5 clk = ~clk;

    // One pixel's products for every input channel plus its expected sum.
    typedef struct packed {
        logic [CIN-1:0][31:0] prod;
        logic [31:0]          expv;
    } pix_vec_t;

    typedef struct {
        logic [31:0] val;
        logic        fd;
        logic        ld;
        int          cyc;
    } out_rec_t;

    pix_vec_t    tbl [NPIX];
    out_rec_t    exp_q [$];
    out_rec_t    out_q [$];
    int          cyc      = 0;
    int          n_checks = 0;
    int          n_errs   = 0;
    int          stray    = 0;

    // FP32 encodings of the integers 0..9, and of 3p+3 for p = 0..7.
    logic [31:0] fp_int [10] = '{32'h0000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
                                 32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000,
                                 32'h4100_0000, 32'h4110_0000};
    logic [31:0] exp_dist [NPIX] = '{32'h4040_0000, 32'h40C0_0000, 32'h4110_0000, 32'h4140_0000,
                                     32'h4170_0000, 32'h4190_0000, 32'h41A8_0000, 32'h41C0_0000};

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        out_rec_t r;
        if (valid_out) begin
            r.val = pxl_out; r.fd = frame_done; r.ld = layer_done; r.cyc = cyc;
            out_q.push_back(r);
        end else if (frame_done || layer_done) begin
            stray++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errs++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Exact FP32 encoding of k/16 for |k| < 2^23.
    function automatic logic [31:0] int_to_fp(input int k);
        int m, hb;
        logic [31:0] r;
        if (k == 0) return 32'h0;
        m  = (k < 0) ? -k : k;
        hb = 0;
        for (int i = 0; i < 31; i++) if (m >= (1 << i)) hb = i;
        r[31]    = (k < 0);
        r[30:23] = 8'(127 + hb - 4);
        r[22:0]  = 23'((m << (23 - hb)) & 32'h007F_FFFF);
        return r;
    endfunction

    task automatic fill_const(input logic [31:0] c0, input logic [31:0] cn, input logic [31:0] expv);
        for (int p = 0; p < NPIX; p++) begin
            tbl[p].prod[0] = c0;
            for (int c = 1; c < CIN; c++) tbl[p].prod[c] = cn;
            tbl[p].expv = expv;
        end
    endtask

    task automatic fill_distinct();
        for (int p = 0; p < NPIX; p++) begin
            for (int c = 0; c < CIN; c++) tbl[p].prod[c] = fp_int[p + c];
            tbl[p].expv = exp_dist[p];
        end
    endtask

    task automatic fill_random();
        int k, sumk;
        for (int p = 0; p < NPIX; p++) begin
            sumk = 0;
            for (int c = 0; c < CIN; c++) begin
                k = int'($urandom_range(4095)) - 2048;
                tbl[p].prod[c] = int_to_fp(k);
                sumk += k;
            end
            tbl[p].expv = int_to_fp(sumk);
        end
    endtask

    task automatic put(input logic [31:0] v, output int samp);
        @(posedge clk);
        #1;
        valid_in = 1'b1;
        pxl_in   = v;
        samp     = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            valid_in = 1'b0;
        end
    endtask

    // Drive the table channel-major; expectations are queued for last-channel products.
    task automatic drive_frame(input int gap_pct, input bit layer_last);
        int samp;
        out_rec_t r;
        for (int c = 0; c < CIN; c++) begin
            for (int p = 0; p < NPIX; p++) begin
                if (gap_pct > 0) while (int'($urandom_range(99)) < gap_pct) idle(1);
                put(tbl[p].prod[c], samp);
                if (c == CIN - 1) begin
                    r.val = tbl[p].expv;
                    r.fd  = (p == NPIX - 1);
                    r.ld  = layer_last && (p == NPIX - 1);
                    r.cyc = samp + LAT + 1;
                    exp_q.push_back(r);
                end
            end
        end
    endtask

    task automatic verify(input string name);
        int waited = 0;
        while (out_q.size() < exp_q.size() && waited < 400) begin
            @(posedge clk);
            waited++;
        end
        repeat (LAT + 4) @(posedge clk);
        check({name, " count"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            check($sformatf("%s val[%0d]", name, i), out_q[i].val, exp_q[i].val);
            check($sformatf("%s frame_done[%0d]", name, i), out_q[i].fd, exp_q[i].fd);
            check($sformatf("%s layer_done[%0d]", name, i), out_q[i].ld, exp_q[i].ld);
            check($sformatf("%s cycle[%0d]", name, i), out_q[i].cyc, exp_q[i].cyc);
        end
        out_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        valid_in = 1'b0;
        pxl_in   = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        out_q.delete();
        exp_q.delete();
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, " pxl_out"}, pxl_out, 32'h0);
        check({name, " valid_out"}, valid_out, 1'b0);
        check({name, " frame_done"}, frame_done, 1'b0);
        check({name, " layer_done"}, layer_done, 1'b0);
    endtask

    // Abort a frame with reset before (ch, px), then run a clean all-ones frame.
    task automatic abort_run(input int ch, input int px, input string name);
        int samp;
        fill_const(32'h3F80_0000, 32'h3F80_0000, 32'h4040_0000);
        for (int c = 0; c <= ch; c++)
            for (int p = 0; p < NPIX; p++)
                if (c < ch || p < px) put(tbl[p].prod[c], samp);
        @(posedge clk);
        #3;
        reset  = 1'b1;
        pxl_in = 32'h40A0_0000;
        #1;
        check_outputs_zero({name, " in reset"});
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero({name, " held reset"});
        reset    = 1'b0;
        valid_in = 1'b0;
        idle(LAT + 4);
        check({name, " no aborted outputs"}, out_q.size(), 0);
        out_q.delete();
        exp_q.delete();
        drive_frame(0, 1'b0);
        idle(1);
        verify({name, " restart"});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        pxl_in   = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset state");
        reset = 1'b0;

        fill_const(32'h3F80_0000, 32'h3F80_0000, 32'h4040_0000);
        drive_frame(0, 1'b0);
        idle(1);
        verify("ramp");

        do_reset();
        fill_distinct();
        drive_frame(0, 1'b0);
        idle(1);
        verify("distinct");

        do_reset();
        fill_random();
        drive_frame(40, 1'b0);
        fill_random();
        drive_frame(40, 1'b1);
        idle(1);
        verify("random gaps");

        do_reset();
        fill_const(32'h3F80_0000, 32'h3F80_0000, 32'h4040_0000);
        drive_frame(0, 1'b0);
        fill_distinct();
        drive_frame(0, 1'b1);
        fill_const(32'h3F80_0000, 32'h3F80_0000, 32'h4040_0000);
        drive_frame(0, 1'b0);
        idle(1);
        verify("back to back");

        abort_run(1, 4, "abort ch1");
        abort_run(2, 3, "abort ch2");

        do_reset();
        fill_const(32'h8000_0000, 32'h4000_0000, 32'h4080_0000);
        drive_frame(0, 1'b0);
        idle(1);
        verify("neg zero");

        check("stray flags", stray, 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
